// File: rtl/geom_scheduler_if.sv
// Host-side table write/commit handshake plus the presented-triangle output bus.
// GEOM_SCHED_CULL_DEGENERATE_EN adds the cull_count status field.
interface geom_scheduler_if #(
  parameter int IDX_W = 2
);
  logic             wr_valid;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_index;
  logic [59:0]      wr_geometry;
  logic [2:0]       wr_color;
  logic             wr_enable;
  logic             commit;
  logic             commit_pending;
  logic             swap_done;
  logic [59:0]      geometry;
  logic [2:0]       color;
  logic             fill_en;
  logic [IDX_W-1:0] tri_index;
  logic [3:0]       frame_counter;
`ifdef GEOM_SCHED_CULL_DEGENERATE_EN
  logic [3:0]       cull_count;
`endif

  modport master (
    output wr_valid, wr_index, wr_geometry, wr_color, wr_enable, commit,
`ifdef GEOM_SCHED_CULL_DEGENERATE_EN
    input  cull_count,
`endif
    input  wr_ready, commit_pending, swap_done, geometry, color, fill_en,
           tri_index, frame_counter
  );

  modport slave (
    input  wr_valid, wr_index, wr_geometry, wr_color, wr_enable, commit,
`ifdef GEOM_SCHED_CULL_DEGENERATE_EN
    output cull_count,
`endif
    output wr_ready, commit_pending, swap_done, geometry, color, fill_en,
           tri_index, frame_counter
  );
endinterface

// File: rtl/geom_scheduler.sv
// geom_scheduler: double-buffered triangle table, rotated per frame; GEOM_SCHED_CULL_DEGENERATE_EN culls zero-area entries.
// Latency: outputs update one cycle after a vsync rise or on swap completion; a swap copies one entry per cycle.
// Backpressure: wr_ready is low for the NUM_TRIS copy cycles; commits while armed or copying are ignored.
module geom_scheduler #(
  parameter int NUM_TRIS       = 4,
  parameter int FRAMES_PER_TRI = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vsync,
  geom_scheduler_if.slave bus
);
  localparam int               IDX_W     = $clog2(NUM_TRIS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TRIS - 1);
  localparam logic [3:0]       DWELL_MAX = 4'(FRAMES_PER_TRI);

  typedef enum logic [1:0] {IDLE, ARMED, COPY} state_t;

  typedef struct packed {
    logic [59:0] geometry;
    logic [2:0]  color;
    logic        enable;
  } tri_entry_t;

  state_t           state, state_nxt;
  tri_entry_t       shadow_tbl [NUM_TRIS];
  tri_entry_t       active_tbl [NUM_TRIS];
  tri_entry_t       view_tbl   [NUM_TRIS];
  tri_entry_t       copy_entry;

  logic             vsync_q, evt;
  logic [IDX_W-1:0] copy_idx;
  logic             copy_last, copy_cull;
  logic [3:0]       dwell_q, dwell_inc;
  logic             dwell_wrap, rotate_evt;

  logic             first_found, next_found, pres_do, pres_found;
  logic [IDX_W-1:0] first_idx, next_idx, pres_idx, cand;

  logic [59:0]      geometry_q;
  logic [2:0]       color_q;
  logic             fill_en_q;
  logic [IDX_W-1:0] tri_index_q;
  logic [3:0]       frame_counter_q;
  logic             wr_ready_q, commit_pending_q, swap_done_q;

  assign evt        = vsync & ~vsync_q;
  assign copy_last  = (state == COPY) && (copy_idx == LAST_IDX);
  assign rotate_evt = (state == IDLE) && evt;
  assign dwell_inc  = dwell_q + 4'd1;
  assign dwell_wrap = dwell_inc >= DWELL_MAX;

`ifdef GEOM_SCHED_CULL_DEGENERATE_EN
  logic [59:0]        src_geom;
  logic signed [10:0] dx1, dy1, dx2, dy2;
  logic signed [21:0] ex1, ey1, ex2, ey2, cross;
  logic [3:0]         cull_q;

  // Zero edge-vector cross product means collinear vertices: nothing to fill.
  always_comb begin
    src_geom = shadow_tbl[copy_idx].geometry;
    dx1      = {1'b0, src_geom[39:30]} - {1'b0, src_geom[59:50]};
    dy1      = {1'b0, src_geom[29:20]} - {1'b0, src_geom[49:40]};
    dx2      = {1'b0, src_geom[19:10]} - {1'b0, src_geom[59:50]};
    dy2      = {1'b0, src_geom[9:0]}   - {1'b0, src_geom[49:40]};
    ex1      = {{11{dx1[10]}}, dx1};
    ey1      = {{11{dy1[10]}}, dy1};
    ex2      = {{11{dx2[10]}}, dx2};
    ey2      = {{11{dy2[10]}}, dy2};
    cross    = ex1 * ey2 - ey1 * ex2;
    copy_cull = (cross == 22'sd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cull_q <= 4'd0;
    end else if ((state == ARMED) && evt) begin
      cull_q <= 4'd0;
    end else if ((state == COPY) && shadow_tbl[copy_idx].enable && copy_cull &&
                 (cull_q != 4'hF)) begin
      cull_q <= cull_q + 4'd1;
    end
  end

  assign bus.cull_count = cull_q;
`else
  assign copy_cull = 1'b0;
`endif

  always_comb begin
    copy_entry        = shadow_tbl[copy_idx];
    copy_entry.enable = shadow_tbl[copy_idx].enable & ~copy_cull;
  end

  // The last entry lands in the active table on the same edge the outputs
  // are loaded, so the selection sees it through this bypass.
  always_comb begin
    for (int i = 0; i < NUM_TRIS; i++) view_tbl[i] = active_tbl[i];
    if (copy_last) view_tbl[NUM_TRIS-1] = copy_entry;

    first_found = 1'b0;
    first_idx   = '0;
    for (int i = NUM_TRIS - 1; i >= 0; i--) begin
      if (view_tbl[i].enable) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
    end

    next_found = 1'b0;
    next_idx   = tri_index_q;
    cand       = '0;
    for (int k = NUM_TRIS; k >= 1; k--) begin
      cand = tri_index_q + IDX_W'(k);
      if (view_tbl[cand].enable) begin
        next_found = 1'b1;
        next_idx   = cand;
      end
    end

    pres_do    = copy_last || (rotate_evt && dwell_wrap);
    pres_found = copy_last ? first_found : next_found;
    pres_idx   = copy_last ? first_idx   : next_idx;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.commit) state_nxt = ARMED;
      ARMED:   if (evt) state_nxt = COPY;
      COPY:    if (copy_idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      vsync_q          <= 1'b0;
      frame_counter_q  <= 4'd0;
      copy_idx         <= '0;
      dwell_q          <= 4'd0;
      geometry_q       <= 60'd0;
      color_q          <= 3'd0;
      fill_en_q        <= 1'b0;
      tri_index_q      <= '0;
      wr_ready_q       <= 1'b0;
      commit_pending_q <= 1'b0;
      swap_done_q      <= 1'b0;
      for (int i = 0; i < NUM_TRIS; i++) begin
        shadow_tbl[i].enable <= 1'b0;
        active_tbl[i].enable <= 1'b0;
      end
    end else begin
      state            <= state_nxt;
      vsync_q          <= vsync;
      wr_ready_q       <= (state_nxt != COPY);
      commit_pending_q <= (state_nxt != IDLE);
      swap_done_q      <= copy_last;
      if (evt) frame_counter_q <= frame_counter_q + 4'd1;

      if (bus.wr_valid && wr_ready_q)
        shadow_tbl[bus.wr_index] <= '{geometry: bus.wr_geometry,
                                      color:    bus.wr_color,
                                      enable:   bus.wr_enable};

      if ((state == ARMED) && evt) copy_idx <= '0;
      else if (state == COPY)      copy_idx <= copy_idx + IDX_W'(1);
      if (state == COPY) active_tbl[copy_idx] <= copy_entry;

      if (copy_last)       dwell_q <= 4'd0;
      else if (rotate_evt) dwell_q <= dwell_wrap ? 4'd0 : dwell_inc;

      if (pres_do) begin
        if (pres_found) begin
          geometry_q  <= view_tbl[pres_idx].geometry;
          color_q     <= view_tbl[pres_idx].color;
          fill_en_q   <= 1'b1;
          tri_index_q <= pres_idx;
        end else begin
          geometry_q  <= 60'd0;
          color_q     <= 3'd0;
          fill_en_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.wr_ready       = wr_ready_q;
  assign bus.commit_pending = commit_pending_q;
  assign bus.swap_done      = swap_done_q;
  assign bus.geometry       = geometry_q;
  assign bus.color          = color_q;
  assign bus.fill_en        = fill_en_q;
  assign bus.tri_index      = tri_index_q;
  assign bus.frame_counter  = frame_counter_q;
endmodule

// File: tb/tb_geom_scheduler.sv
// Directed bench for geom_scheduler with NUM_TRIS=4, FRAMES_PER_TRI=1.
module tb_geom_scheduler;
  logic clk = 1'b0;
  logic reset;
  logic vsync;
  always #5 clk = ~clk;

  geom_scheduler_if #(.IDX_W(2)) bus();
  geom_scheduler #(.NUM_TRIS(4), .FRAMES_PER_TRI(1)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [59:0] e0, e1, e2, e3;

  function automatic logic [59:0] pack_geom(input int x0, y0, x1, y1, x2, y2);
    return {10'(x0), 10'(y0), 10'(x1), 10'(y1), 10'(x2), 10'(y2)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] idx, input logic [59:0] g,
                             input logic [2:0] c, input logic en);
    bus.wr_valid = 1'b1; bus.wr_index = idx; bus.wr_geometry = g;
    bus.wr_color = c; bus.wr_enable = en;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic commit_pulse();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  // One low cycle then a rising edge; returns sampled just after the event edge.
  task automatic frame();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic wait_swap(output bit got);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.swap_done) begin got = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    vsync = 1'b0;
    repeat (3) begin vsync = ~vsync; tick(); end
    checks++; if (bus.geometry !== 60'd0) begin errors++; $display("FAIL reset_geometry: got %h expected 0", bus.geometry); end
    checks++; if (bus.fill_en !== 1'b0) begin errors++; $display("FAIL reset_fill_en: got %b expected 0", bus.fill_en); end
    checks++; if (bus.frame_counter !== 4'd0) begin errors++; $display("FAIL reset_frame_counter: got %0d expected 0", bus.frame_counter); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", bus.wr_ready); end
    reset = 1'b1;
    vsync = 1'b0;
    tick();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL release_wr_ready: got %b expected 1", bus.wr_ready); end
  endtask

  task automatic test_swap();
    int cnt;
    bit got;
    write_entry(2'd0, e0, 3'b001, 1'b1);
    write_entry(2'd2, e2, 3'b011, 1'b1);
    commit_pulse();
    checks++; if (bus.commit_pending !== 1'b1) begin errors++; $display("FAIL swap_pending: got %b expected 1", bus.commit_pending); end
    checks++; if (bus.fill_en !== 1'b0) begin errors++; $display("FAIL swap_pre_fill: got %b expected 0", bus.fill_en); end
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    cnt = 0;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.swap_done) begin got = 1'b1; break; end
      if (!bus.wr_ready) cnt++;
      tick();
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL swap_done_seen: got %b expected 1", got); end
    checks++; if (cnt != 4) begin errors++; $display("FAIL swap_copy_cycles: got %0d expected 4", cnt); end
    checks++; if (bus.geometry !== e0) begin errors++; $display("FAIL swap_geometry: got %h expected %h", bus.geometry, e0); end
    checks++; if (bus.tri_index !== 2'd0) begin errors++; $display("FAIL swap_tri_index: got %0d expected 0", bus.tri_index); end
    checks++; if (bus.fill_en !== 1'b1) begin errors++; $display("FAIL swap_fill_en: got %b expected 1", bus.fill_en); end
    checks++; if (bus.color !== 3'b001) begin errors++; $display("FAIL swap_color: got %b expected 001", bus.color); end
    checks++; if (bus.frame_counter !== 4'd1) begin errors++; $display("FAIL swap_frame_counter: got %0d expected 1", bus.frame_counter); end
    tick();
    checks++; if (bus.swap_done !== 1'b0) begin errors++; $display("FAIL swap_done_pulse: got %b expected 0", bus.swap_done); end
    checks++; if (bus.commit_pending !== 1'b0) begin errors++; $display("FAIL swap_pending_clear: got %b expected 0", bus.commit_pending); end
  endtask

  task automatic test_rotation();
    frame();
    checks++; if (bus.tri_index !== 2'd2) begin errors++; $display("FAIL rot1_tri_index: got %0d expected 2", bus.tri_index); end
    checks++; if (bus.geometry !== e2) begin errors++; $display("FAIL rot1_geometry: got %h expected %h", bus.geometry, e2); end
    checks++; if (bus.color !== 3'b011) begin errors++; $display("FAIL rot1_color: got %b expected 011", bus.color); end
    checks++; if (bus.frame_counter !== 4'd2) begin errors++; $display("FAIL rot1_frame_counter: got %0d expected 2", bus.frame_counter); end
    repeat (3) tick();
    checks++; if (bus.tri_index !== 2'd2) begin errors++; $display("FAIL rot_hold_tri_index: got %0d expected 2", bus.tri_index); end
    frame();
    checks++; if (bus.tri_index !== 2'd0) begin errors++; $display("FAIL rot2_tri_index: got %0d expected 0", bus.tri_index); end
    checks++; if (bus.geometry !== e0) begin errors++; $display("FAIL rot2_geometry: got %h expected %h", bus.geometry, e0); end
    checks++; if (bus.frame_counter !== 4'd3) begin errors++; $display("FAIL rot2_frame_counter: got %0d expected 3", bus.frame_counter); end
  endtask

  task automatic test_armed_write();
    bit got;
    commit_pulse();
    commit_pulse();
    checks++; if (bus.commit_pending !== 1'b1) begin errors++; $display("FAIL armed_pending: got %b expected 1", bus.commit_pending); end
    vsync = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_index = 2'd1; bus.wr_geometry = e1;
    bus.wr_color = 3'b110; bus.wr_enable = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    vsync = 1'b0;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL copy_wr_ready: got %b expected 0", bus.wr_ready); end
    write_entry(2'd3, e3, 3'b111, 1'b1);
    wait_swap(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL armed_swap_seen: got %b expected 1", got); end
    checks++; if (bus.tri_index !== 2'd0) begin errors++; $display("FAIL armed_tri_index: got %0d expected 0", bus.tri_index); end
    checks++; if (bus.frame_counter !== 4'd4) begin errors++; $display("FAIL armed_frame_counter: got %0d expected 4", bus.frame_counter); end
    frame();
    checks++; if (bus.tri_index !== 2'd1) begin errors++; $display("FAIL armed_rot1_tri_index: got %0d expected 1", bus.tri_index); end
    checks++; if (bus.geometry !== e1) begin errors++; $display("FAIL armed_rot1_geometry: got %h expected %h", bus.geometry, e1); end
    checks++; if (bus.color !== 3'b110) begin errors++; $display("FAIL armed_rot1_color: got %b expected 110", bus.color); end
    frame();
    checks++; if (bus.tri_index !== 2'd2) begin errors++; $display("FAIL armed_rot2_tri_index: got %0d expected 2", bus.tri_index); end
    frame();
    checks++; if (bus.tri_index !== 2'd0) begin errors++; $display("FAIL armed_rot3_tri_index: got %0d expected 0", bus.tri_index); end
    checks++; if (bus.swap_done !== 1'b0) begin errors++; $display("FAIL armed_no_extra_swap: got %b expected 0", bus.swap_done); end
    checks++; if (bus.commit_pending !== 1'b0) begin errors++; $display("FAIL armed_no_pending: got %b expected 0", bus.commit_pending); end
  endtask

  task automatic test_all_disabled();
    bit got;
    logic [3:0] exp_fc;
    for (int i = 0; i < 4; i++) write_entry(2'(i), e3, 3'b111, 1'b0);
    commit_pulse();
    frame();
    wait_swap(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL dis_swap_seen: got %b expected 1", got); end
    checks++; if (bus.fill_en !== 1'b0) begin errors++; $display("FAIL dis_fill_en: got %b expected 0", bus.fill_en); end
    checks++; if (bus.geometry !== 60'd0) begin errors++; $display("FAIL dis_geometry: got %h expected 0", bus.geometry); end
    checks++; if (bus.color !== 3'd0) begin errors++; $display("FAIL dis_color: got %b expected 000", bus.color); end
    checks++; if (bus.frame_counter !== 4'd8) begin errors++; $display("FAIL dis_frame_counter: got %0d expected 8", bus.frame_counter); end
    for (int k = 1; k <= 8; k++) begin
      frame();
      exp_fc = 4'(8 + k);
      checks++; if (bus.fill_en !== 1'b0 || bus.geometry !== 60'd0) begin errors++; $display("FAIL dis_frame%0d_output: got fill %b geom %h expected 0/0", k, bus.fill_en, bus.geometry); end
      checks++; if (bus.frame_counter !== exp_fc) begin errors++; $display("FAIL dis_frame%0d_counter: got %0d expected %0d", k, bus.frame_counter, exp_fc); end
    end
  endtask

  task automatic test_reset_mid_copy();
    bit got;
    write_entry(2'd0, e0, 3'b001, 1'b1);
    commit_pulse();
    frame();
    wait_swap(got);
    checks++; if (bus.fill_en !== 1'b1 || bus.geometry !== e0) begin errors++; $display("FAIL mid_pre_output: got fill %b geom %h expected 1/%h", bus.fill_en, bus.geometry, e0); end
    commit_pulse();
    frame();
    tick();
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL mid_in_copy: got %b expected 0", bus.wr_ready); end
    reset = 1'b0;
    tick();
    checks++; if (bus.geometry !== 60'd0 || bus.color !== 3'd0 || bus.fill_en !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got geom %h color %b fill %b expected 0", bus.geometry, bus.color, bus.fill_en); end
    checks++; if (bus.tri_index !== 2'd0 || bus.frame_counter !== 4'd0) begin errors++; $display("FAIL mid_reset_counters: got tri %0d fc %0d expected 0/0", bus.tri_index, bus.frame_counter); end
    checks++; if (bus.wr_ready !== 1'b0 || bus.commit_pending !== 1'b0 || bus.swap_done !== 1'b0) begin errors++; $display("FAIL mid_reset_handshake: got rdy %b pend %b done %b expected 0", bus.wr_ready, bus.commit_pending, bus.swap_done); end
    reset = 1'b1;
    tick();
    checks++; if (bus.wr_ready !== 1'b1 || bus.commit_pending !== 1'b0) begin errors++; $display("FAIL mid_idle: got rdy %b pend %b expected 1/0", bus.wr_ready, bus.commit_pending); end
    frame();
    checks++; if (bus.fill_en !== 1'b0 || bus.geometry !== 60'd0) begin errors++; $display("FAIL mid_active_disabled: got fill %b geom %h expected 0/0", bus.fill_en, bus.geometry); end
    checks++; if (bus.frame_counter !== 4'd1 || bus.swap_done !== 1'b0) begin errors++; $display("FAIL mid_post_frame: got fc %0d done %b expected 1/0", bus.frame_counter, bus.swap_done); end
  endtask

`ifdef GEOM_SCHED_CULL_DEGENERATE_EN
  task automatic test_cull();
    bit got;
    write_entry(2'd0, pack_geom(10, 10, 20, 20, 30, 30), 3'b101, 1'b1);
    write_entry(2'd1, e1, 3'b110, 1'b1);
    commit_pulse();
    frame();
    wait_swap(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL cull_swap_seen: got %b expected 1", got); end
    checks++; if (bus.cull_count !== 4'd1) begin errors++; $display("FAIL cull_count: got %0d expected 1", bus.cull_count); end
    checks++; if (bus.tri_index !== 2'd1 || bus.geometry !== e1) begin errors++; $display("FAIL cull_present: got tri %0d geom %h expected 1/%h", bus.tri_index, bus.geometry, e1); end
    frame();
    checks++; if (bus.tri_index !== 2'd1) begin errors++; $display("FAIL cull_single_hold: got %0d expected 1", bus.tri_index); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    e0 = pack_geom(100, 1, 1, 100, 200, 200);
    e1 = pack_geom(10, 20, 500, 40, 30, 600);
    e2 = pack_geom(300, 100, 250, 300, 400, 300);
    e3 = pack_geom(5, 6, 700, 8, 9, 900);
    reset = 1'b0; vsync = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_index = 2'd0; bus.wr_geometry = 60'd0;
    bus.wr_color = 3'd0; bus.wr_enable = 1'b0; bus.commit = 1'b0;
    test_reset();
    test_swap();
    test_rotation();
    test_armed_write();
    test_all_disabled();
    test_reset_mid_copy();
`ifdef GEOM_SCHED_CULL_DEGENERATE_EN
    test_cull();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
